ecc_dual_mem_responder: RTL and testbench
=========================================

Name: ecc_dual_mem_responder

Overview:
- Memory-side responder for the ECC bridge. It models the two 16-bit memory banks ("up" and "down") that sit behind the bridge's right-hand ports.
- It stores the 32-bit codeword halves written by the bridge and returns them on reads through a valid/ready handshake with configurable read latency.
- It is used as the bench/system counterpart for bypass and ECC modes. It can also corrupt read data, so the TBEC_RSC and MRSC decode paths can be exercised.

Parameters:
- ADDR_W, 8, address width in bits; depth is 2**ADDR_W words per bank.
- RD_LAT, 2, cycles from read accept to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address, shared by both banks.
- req_bank_en  input  2  bit1 = up bank, bit0 = down bank.
- wdata_up  input  16 [0:15]  write data for the up bank (codeword bits 0:15).
- wdata_down  input  16 [0:15]  write data for the down bank (codeword bits 16:31).
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer takes the response.
- rdata_up  output  16 [0:15]  read data, up bank.
- rdata_down  output  16 [0:15]  read data, down bank.
- busy  output  1  high whenever state is not IDLE.
- inj_mask_up  input  16 [0:15]  XOR mask for the up bank (FAULT_INJECT_EN only).
- inj_mask_down  input  16 [0:15]  XOR mask for the down bank (FAULT_INJECT_EN only).
- inj_count  output  8  responses carrying a nonzero mask, saturating (FAULT_INJECT_EN only).

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rdata_up=rdata_down=16'h0000, busy=0, lat counter=0, inj_count=0.
- Memory arrays are not cleared by reset; their contents are undefined until written.
- Accept condition: req_valid && req_ready. req_ready = (state==IDLE).

FSM states and transitions:
- IDLE:
  - Write accept: each bank with its req_bank_en bit set takes its wdata at that edge; disabled banks are untouched. State stays IDLE. No response is generated.
  - Read accept: the enabled banks' words at req_addr are snapshotted into the response registers; a disabled bank yields 16'h0000. Lat counter loads RD_LAT-1. Next state is WAIT, or RESP if RD_LAT==1.
- WAIT: counter decrements each cycle; at 0 the next state is RESP. req_ready=0; req_valid is ignored.
- RESP: rsp_valid=1; rdata holds stable until rsp_ready=1. On that cycle the next state is IDLE, rsp_valid drops and rdata returns to 0.
- Read latency: rsp_valid first asserts exactly RD_LAT cycles after the accept edge.
- Throughput: a new request is accepted, at the earliest, the cycle after the handshake that returns the FSM to IDLE.

Boundaries:
- Read of an address written on the previous cycle returns the new data.
- req_bank_en=2'b00 read: completes normally with both halves 0. req_bank_en=2'b00 write: acts as a no-op.
- Address wraps naturally within ADDR_W bits; there is no out-of-range case.
- rsp_ready held high while idle has no effect.
- Reset asserted mid-WAIT or mid-RESP: immediate return to IDLE with outputs at reset values. The pending response is discarded and memory contents are kept.

Optional Feature:
- Macro FAULT_INJECT_EN.
- Defined:
  - inj_mask_up/inj_mask_down are sampled at read accept and XORed into the snapshotted data. This applies to enabled banks only; a disabled bank stays 0.
  - inj_count increments at response handshake when the applied mask is nonzero, saturating at 8'hFF.
  - Stored memory data is never modified.
- Not defined: inj_mask_*/inj_count ports are absent and responses equal stored data exactly.

Test Plan:
- Write addr 8'h10, bank_en=2'b11, up=16'hA5A5, down=16'h5A5A; read 8'h10 with rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rdata_up=16'hA5A5, rdata_down=16'h5A5A.
- Write 8'h20 up=16'h1234 with bank_en=2'b10, then read with bank_en=2'b01 -> rdata_up=16'h0000 and rdata_down equal to the prior down content at 8'h20 (written 16'hBEEF earlier).
- Read with rsp_ready held low for 5 cycles -> rsp_valid and rdata stable throughout; req_ready=0 and a concurrent write request is not accepted; memory is unchanged.
- rst_n pulsed low during WAIT -> rsp_valid=0 and req_ready=1 immediately; a subsequent read of 8'h10 still returns 16'hA5A5/16'h5A5A.
- RD_LAT=1 build: back-to-back reads of 8'h10 and 8'h11 with rsp_ready=1 -> responses 1 cycle after each accept; accepts are spaced 2 cycles apart.
- FAULT_INJECT_EN: inj_mask_up=16'h0001 on a read of 8'h10 -> rdata_up=16'hA5A4, inj_count=1. A repeat read with the mask at 0 returns 16'hA5A5 and inj_count stays 1.

Source files
------------

// File: rtl/ecc_dual_mem_responder.sv
// Two-bank (up/down) 16-bit memory responder behind the ECC bridge, with a valid/ready
// read path of RD_LAT cycles. Optional read-data corruption is enabled by FAULT_INJECT_EN.
module ecc_dual_mem_responder #(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_bank_en,
   input  logic [0:15]       wdata_up,
   input  logic [0:15]       wdata_down,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [0:15]       rdata_up,
   output logic [0:15]       rdata_down,
   output logic              busy,
`ifdef FAULT_INJECT_EN
   input  logic [0:15]       inj_mask_up,
   input  logic [0:15]       inj_mask_down,
   output logic [7:0]        inj_count,
`endif
   output logic [1:0]        dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // producer holds valid and its payload stable until that edge.
   logic [1:0]  state;
   logic [3:0]  lat_cnt;
   logic [0:15] mem_up   [0:(1<<ADDR_W)-1];
   logic [0:15] mem_down [0:(1<<ADDR_W)-1];
   logic [0:15] mask_up_eff;
   logic [0:15] mask_down_eff;
   logic [0:15] rd_up;
   logic [0:15] rd_down;
   logic        wr_acc;
   logic        rd_acc;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);
   assign dbg_state = state;
   assign wr_acc    = req_valid && req_ready && req_we;
   assign rd_acc    = req_valid && req_ready && !req_we;

`ifdef FAULT_INJECT_EN
   assign mask_up_eff   = inj_mask_up;
   assign mask_down_eff = inj_mask_down;
`else
   assign mask_up_eff   = '0;
   assign mask_down_eff = '0;
`endif

   // A disabled bank reads as zero, and the corruption mask never reaches it.
   assign rd_up   = req_bank_en[1] ? (mem_up[req_addr] ^ mask_up_eff) : '0;
   assign rd_down = req_bank_en[0] ? (mem_down[req_addr] ^ mask_down_eff) : '0;

   // Storage is deliberately left out of reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         if (req_bank_en[1]) mem_up[req_addr] <= wdata_up;
         if (req_bank_en[0]) mem_down[req_addr] <= wdata_down;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         rdata_up   <= '0;
         rdata_down <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_acc) begin
                  rdata_up   <= rd_up;
                  rdata_down <= rd_down;
                  lat_cnt    <= 4'(RD_LAT - 1);
                  state      <= (RD_LAT == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               // The response becomes visible in the cycle where the count reaches zero.
               lat_cnt <= lat_cnt - 4'd1;
               if (lat_cnt <= 4'd1) state <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  state      <= IDLE;
                  rdata_up   <= '0;
                  rdata_down <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FAULT_INJECT_EN
   logic inj_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_pend  <= 1'b0;
         inj_count <= '0;
      end else begin
         if (rd_acc)
            inj_pend <= (req_bank_en[1] && (|inj_mask_up)) ||
                        (req_bank_en[0] && (|inj_mask_down));
         if (rsp_valid && rsp_ready && inj_pend && (inj_count != 8'hFF))
            inj_count <= inj_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ecc_dual_mem_responder.sv
// Bench for ecc_dual_mem_responder: table-driven write/read vectors against a scoreboard
// queue, plus hand sequences for stall, reset-in-flight, RD_LAT=1 and fault injection.
module tb_ecc_dual_mem_responder;

   localparam int RD_LAT  = 2;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, busy;
   logic [7:0]  req_addr;
   logic [1:0]  req_bank_en, dbg_state;
   logic [15:0] wdata_up, wdata_down, rdata_up, rdata_down;

   logic        req_valid1, req_we1, req_ready1, rsp_valid1, rsp_ready1, busy1;
   logic [7:0]  req_addr1;
   logic [1:0]  req_bank_en1, dbg_state1;
   logic [15:0] wdata_up1, wdata_down1, rdata_up1, rdata_down1;

`ifdef FAULT_INJECT_EN
   logic [15:0] inj_mask_up, inj_mask_down, inj_mask_up1, inj_mask_down1;
   logic [7:0]  inj_count, inj_count1;
`endif

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];
   logic [15:0] m_up [256];
   logic [15:0] m_dn [256];

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [1:0]  en;
      logic [15:0] up;
      logic [15:0] dn;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [12];

   always #5 clk = ~clk;

   ecc_dual_mem_responder #(.ADDR_W(8), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_bank_en(req_bank_en),
      .wdata_up(wdata_up), .wdata_down(wdata_down), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rdata_up(rdata_up), .rdata_down(rdata_down), .busy(busy),
`ifdef FAULT_INJECT_EN
      .inj_mask_up(inj_mask_up), .inj_mask_down(inj_mask_down), .inj_count(inj_count),
`endif
      .dbg_state(dbg_state)
   );

   ecc_dual_mem_responder #(.ADDR_W(8), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_we(req_we1), .req_addr(req_addr1), .req_bank_en(req_bank_en1),
      .wdata_up(wdata_up1), .wdata_down(wdata_down1), .rsp_valid(rsp_valid1),
      .rsp_ready(rsp_ready1), .rdata_up(rdata_up1), .rdata_down(rdata_down1), .busy(busy1),
`ifdef FAULT_INJECT_EN
      .inj_mask_up(inj_mask_up1), .inj_mask_down(inj_mask_down1), .inj_count(inj_count1),
`endif
      .dbg_state(dbg_state1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every completed response handshake consumes one expected word.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) chk("unexpected_rsp", {rdata_up, rdata_down}, 32'hxxxxxxxx);
         else chk("rsp_data", {rdata_up, rdata_down}, exp_q.pop_front());
      end
   end

   task automatic do_write(input logic [7:0] a, input logic [1:0] en,
                           input logic [15:0] up, input logic [15:0] dn);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_bank_en = en;
      wdata_up = up; wdata_down = dn;
      chk("wr_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0; req_we = 1'b0;
      if (en[1]) m_up[a] = up;
      if (en[0]) m_dn[a] = dn;
   endtask

   task automatic do_read(input logic [7:0] a, input logic [1:0] en,
                          input logic [31:0] exp, input int hold);
      int lat;
      logic [31:0] snap;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_bank_en = en;
      rsp_ready = (hold == 0);
      chk("rd_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back(exp);
      #1 req_valid = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      lat = 1;
      while (!rsp_valid && lat < TIMEOUT) begin
         @(posedge clk); #1 lat++;
      end
      chk("rd_latency", lat, RD_LAT);
      if (!rsp_valid) return;
      snap = {rdata_up, rdata_down};
      for (int i = 0; i < hold; i++) begin
         if (i == 0) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_bank_en = 2'b11;
            wdata_up = 16'h0000; wdata_down = 16'h0000;
         end
         @(posedge clk); #1;
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_data", {rdata_up, rdata_down}, snap);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_hs_data", {rdata_up, rdata_down}, 32'd0);
      chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [7:0]  a;
      logic [1:0]  en;
      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_addr = 0; req_bank_en = 0;
      wdata_up = 0; wdata_down = 0; rsp_ready = 0;
      req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_bank_en1 = 0;
      wdata_up1 = 0; wdata_down1 = 0; rsp_ready1 = 1;
`ifdef FAULT_INJECT_EN
      inj_mask_up = 0; inj_mask_down = 0; inj_mask_up1 = 0; inj_mask_down1 = 0;
`endif
      vecs[0]  = '{1'b1, 8'h10, 2'b11, 16'hA5A5, 16'h5A5A, 32'h0};
      vecs[1]  = '{1'b1, 8'h20, 2'b11, 16'h0000, 16'hBEEF, 32'h0};
      vecs[2]  = '{1'b0, 8'h10, 2'b11, 16'h0000, 16'h0000, 32'hA5A5_5A5A};
      vecs[3]  = '{1'b1, 8'h20, 2'b10, 16'h1234, 16'hFFFF, 32'h0};
      vecs[4]  = '{1'b0, 8'h20, 2'b01, 16'h0000, 16'h0000, 32'h0000_BEEF};
      vecs[5]  = '{1'b0, 8'h20, 2'b10, 16'h0000, 16'h0000, 32'h1234_0000};
      vecs[6]  = '{1'b0, 8'h20, 2'b00, 16'h0000, 16'h0000, 32'h0000_0000};
      vecs[7]  = '{1'b1, 8'h30, 2'b11, 16'h1111, 16'h2222, 32'h0};
      vecs[8]  = '{1'b1, 8'h30, 2'b00, 16'hFFFF, 16'hFFFF, 32'h0};
      vecs[9]  = '{1'b0, 8'h30, 2'b11, 16'h0000, 16'h0000, 32'h1111_2222};
      vecs[10] = '{1'b1, 8'hFF, 2'b11, 16'hCAFE, 16'hF00D, 32'h0};
      vecs[11] = '{1'b0, 8'hFF, 2'b11, 16'h0000, 16'h0000, 32'hCAFE_F00D};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rdata", {rdata_up, rdata_down}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef FAULT_INJECT_EN
      chk("rst_inj_count", {24'd0, inj_count}, 32'd0);
`endif
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].we) do_write(vecs[i].addr, vecs[i].en, vecs[i].up, vecs[i].dn);
         else do_read(vecs[i].addr, vecs[i].en, vecs[i].exp, 0);
      end

      for (int i = 0; i < 8; i++) begin
         a  = 8'($urandom_range(8'h40, 8'hEF));
         en = 2'($urandom_range(0, 3));
         do_write(a, 2'b11, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
         do_read(a, en, {en[1] ? m_up[a] : 16'h0, en[0] ? m_dn[a] : 16'h0}, 0);
      end

      // Stalled response with a competing write, then confirm memory was untouched.
      do_read(8'h10, 2'b11, 32'hA5A5_5A5A, 5);
      do_read(8'h10, 2'b11, 32'hA5A5_5A5A, 0);

      // Reset pulse while the read is still waiting: response is dropped.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_bank_en = 2'b11;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("wait_state", {30'd0, dbg_state}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      chk("midrst_rdata", {rdata_up, rdata_down}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      do_read(8'h10, 2'b11, 32'hA5A5_5A5A, 0);

      // Single-cycle latency instance: back-to-back reads.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 8'(8'h10 + i); req_bank_en1 = 2'b11;
         wdata_up1 = (i == 0) ? 16'h1111 : 16'h3333;
         wdata_down1 = (i == 0) ? 16'h2222 : 16'h4444;
         @(posedge clk);
         #1 req_valid1 = 1'b0; req_we1 = 1'b0;
      end
      @(negedge clk);
      req_valid1 = 1'b1; req_addr1 = 8'h10;
      @(posedge clk); #1;
      req_addr1 = 8'h11;
      chk("lat1_valid0", {31'd0, rsp_valid1}, 32'd1);
      chk("lat1_data0", {rdata_up1, rdata_down1}, 32'h1111_2222);
      chk("lat1_busy_ready", {31'd0, req_ready1}, 32'd0);
      @(posedge clk); #1;
      chk("lat1_gap_valid", {31'd0, rsp_valid1}, 32'd0);
      chk("lat1_gap_ready", {31'd0, req_ready1}, 32'd1);
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      chk("lat1_valid1", {31'd0, rsp_valid1}, 32'd1);
      chk("lat1_data1", {rdata_up1, rdata_down1}, 32'h3333_4444);
      @(posedge clk); #1;
      chk("lat1_done", {31'd0, rsp_valid1}, 32'd0);

`ifdef FAULT_INJECT_EN
      inj_mask_up = 16'h0001;
      do_read(8'h10, 2'b11, 32'hA5A4_5A5A, 0);
      inj_mask_up = 16'h0000;
      chk("inj_count_1", {24'd0, inj_count}, 32'd1);
      do_read(8'h10, 2'b11, 32'hA5A5_5A5A, 0);
      chk("inj_count_hold", {24'd0, inj_count}, 32'd1);
`endif

      repeat (2) @(posedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
